// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer SPI frame transmitter:
// FSM state encoding, frame geometry defaults and header construction.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_e;

  // 320x240 pixels at 1 bpp, packed into 16-bit words.
  localparam int unsigned FRAME_WORDS_DEF = 4800;
  localparam int unsigned ADDR_WIDTH_DEF  = $clog2(FRAME_WORDS_DEF);
  localparam logic [15:0] HEADER_DEF      = 16'hA5A0;
  localparam logic [3:0]  LAST_BIT        = 4'd15;

  function automatic logic [15:0] frame_header(input logic [15:0] hdr, input logic sel);
    return {hdr[15:1], sel};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin, plus a third flop
// holding the previous synchronized level so any transition can be flagged.
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic edge_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // synchronizer chain and previous-level register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign edge_o  = sync_q ^ prev_q;

endmodule

// File: rtl/spi_frame_tx.sv
// Streams a header word followed by a complete framebuffer out over SPI
// (mode 0, slave side), prefetching each word from the framebuffer.
module spi_frame_tx
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
  parameter logic [15:0] HEADER      = HEADER_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_ready,
  input  logic                  buf_sel,
  output logic                  frame_busy,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [15:0]           rd_data,
  input  logic                  spi_sck,
  input  logic                  spi_ncs,
  output logic                  spi_miso
);

  localparam int unsigned CNT_W = $clog2(FRAME_WORDS + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(FRAME_WORDS);

  logic sck_lvl_s, sck_edge_s, ncs_lvl_s, ncs_edge_s;
  logic sck_fall_s, ncs_fall_s, ncs_rise_s, shift_en_s, word_end_s;

  tx_state_e             state_q, state_d;
  logic                  pending_q, pending_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           shift_q, shift_d;
  logic [15:0]           next_word_q, next_word_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
  logic [1:0]            pf_q, pf_d;

  sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (spi_sck),
    .level_o (sck_lvl_s),
    .edge_o  (sck_edge_s)
  );

  sync_edge #(.RESET_VAL(1'b1)) u_ncs_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (spi_ncs),
    .level_o (ncs_lvl_s),
    .edge_o  (ncs_edge_s)
  );

  assign sck_fall_s = sck_edge_s & ~sck_lvl_s;
  assign ncs_fall_s = ncs_edge_s & ~ncs_lvl_s;
  assign ncs_rise_s = ncs_edge_s & ncs_lvl_s;
  assign shift_en_s = sck_fall_s & ~ncs_lvl_s;
  assign word_end_s = shift_en_s & (bit_cnt_q == LAST_BIT);

  // next-state logic for the transfer FSM, shifter and prefetch pipeline
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | frame_ready;
    busy_d     = busy_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    pf_d       = {pf_q[0], 1'b0};

    // rd_data is valid one clock after the address moves; take it one clock later still
    if (pf_q[1]) begin
      next_word_d = rd_data;
    end else begin
      next_word_d = next_word_q;
    end

    if (ncs_rise_s) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
      shift_d   = 16'h0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ncs_fall_s) begin
            bit_cnt_d = 4'd0;
            if (pending_q) begin
              pending_d  = frame_ready;
              shift_d    = frame_header(HEADER, buf_sel);
              addr_d     = {ADDR_WIDTH{1'b0}};
              pf_d[0]    = 1'b1;
              word_cnt_d = {CNT_W{1'b0}};
              busy_d     = 1'b1;
              state_d    = ST_SEND;
            end else begin
              shift_d = 16'h0000;
            end
          end else if (shift_en_s) begin
            shift_d   = {shift_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            shift_d = shift_q;
          end
        end

        ST_SEND: begin
          if (word_end_s) begin
            bit_cnt_d = 4'd0;
            if (word_cnt_q == LAST_CNT) begin
              shift_d = 16'h0000;
              busy_d  = 1'b0;
              state_d = ST_DRAIN;
            end else begin
              shift_d    = next_word_q;
              word_cnt_d = word_cnt_q + CNT_W'(1);
              pf_d[0]    = 1'b1;
              if (addr_q == LAST_ADDR) begin
                addr_d = addr_q;
              end else begin
                addr_d = addr_q + ADDR_WIDTH'(1);
              end
            end
          end else if (shift_en_s) begin
            shift_d   = {shift_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            shift_d = shift_q;
          end
        end

        ST_DRAIN: begin
          if (shift_en_s) begin
            shift_d   = 16'h0000;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            shift_d = shift_q;
          end
        end

        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          shift_d = 16'h0000;
        end
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      shift_q     <= 16'h0000;
      next_word_q <= 16'h0000;
      bit_cnt_q   <= 4'd0;
      word_cnt_q  <= {CNT_W{1'b0}};
      pf_q        <= 2'b00;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      shift_q     <= shift_d;
      next_word_q <= next_word_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      pf_q        <= pf_d;
    end
  end

  assign frame_busy = busy_q;
  assign rd_addr    = addr_q;
  assign spi_miso   = shift_q[15] & ~ncs_lvl_s;

endmodule

// File: tb/tb_spi_frame_tx.sv
// Scoreboard bench for spi_frame_tx: an SPI master model collects MISO words,
// a monitor compares them against expected words queued by the stimulus.
module tb_spi_frame_tx;

  localparam int FW = 24;
  localparam int AW = 5;

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b1;
  logic          frame_ready = 1'b0;
  logic          buf_sel     = 1'b0;
  logic          spi_sck     = 1'b0;
  logic          spi_ncs     = 1'b1;
  logic [15:0]   rd_data     = 16'h0000;
  logic          frame_busy;
  logic          spi_miso;
  logic [AW-1:0] rd_addr;

  logic [15:0] exp_q[$];
  logic [15:0] rx_q[$];
  event        rx_ev;
  int          n_vec = 0;
  int          n_err = 0;

  spi_frame_tx #(
    .ADDR_WIDTH  (AW),
    .FRAME_WORDS (FW),
    .HEADER      (16'hA5A0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_ready (frame_ready),
    .buf_sel     (buf_sel),
    .frame_busy  (frame_busy),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .spi_sck     (spi_sck),
    .spi_ncs     (spi_ncs),
    .spi_miso    (spi_miso)
  );

  always #5 clk = ~clk;

  // framebuffer model: word[i] = i, one clock read latency
  always @(posedge clk) rd_data <= 16'(rd_addr);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // monitor: compares every word the master received with the scoreboard
  initial begin : monitor
    logic [15:0] w;
    logic [15:0] e;
    forever begin
      @(rx_ev);
      while (rx_q.size() > 0) begin
        w = rx_q.pop_front();
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL miso_word: got %h, expected no word", w);
        end else begin
          e = exp_q.pop_front();
          check("miso_word", 32'(w), 32'(e));
        end
      end
    end
  end

  task automatic spi_words(input int n);
    logic [15:0] w;
    for (int k = 0; k < n; k++) begin
      w = 16'h0000;
      for (int b = 0; b < 16; b++) begin
        repeat (4) @(negedge clk);
        w = {w[14:0], spi_miso};
        spi_sck = 1'b1;
        repeat (4) @(negedge clk);
        spi_sck = 1'b0;
      end
      rx_q.push_back(w);
      -> rx_ev;
    end
  endtask

  task automatic ncs_low();
    repeat (2) @(negedge clk);
    spi_ncs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ncs_high();
    repeat (4) @(negedge clk);
    spi_ncs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_ready(input logic sel);
    @(negedge clk);
    buf_sel     = sel;
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(frame_busy), 32'd0);
    check("reset_miso", 32'(spi_miso), 32'd0);
    check("reset_addr", 32'(rd_addr), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // chip select without a pending frame: zeros only
    ncs_low();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    spi_words(2);
    check("idle_busy", 32'(frame_busy), 32'd0);
    ncs_high();

    // full frame with buf_sel=1; buf_sel changes after the start
    pulse_ready(1'b1);
    ncs_low();
    buf_sel = 1'b0;
    exp_q.push_back(16'hA5A1);
    spi_words(1);
    check("hdr_busy", 32'(frame_busy), 32'd1);
    for (int i = 0; i < FW; i++) exp_q.push_back(16'(i));
    spi_words(FW);
    repeat (4) @(negedge clk);
    check("end_busy", 32'(frame_busy), 32'd0);
    check("sat_addr", 32'(rd_addr), 32'(FW - 1));
    exp_q.push_back(16'h0000);
    spi_words(1);
    check("drain_busy", 32'(frame_busy), 32'd0);
    ncs_high();

    // abort after data word 10, then no resend
    pulse_ready(1'b0);
    ncs_low();
    exp_q.push_back(16'hA5A0);
    for (int i = 0; i <= 10; i++) exp_q.push_back(16'(i));
    spi_words(12);
    check("abort_busy_before", 32'(frame_busy), 32'd1);
    ncs_high();
    check("abort_busy_after", 32'(frame_busy), 32'd0);
    ncs_low();
    exp_q.push_back(16'h0000);
    spi_words(1);
    check("no_resend_busy", 32'(frame_busy), 32'd0);
    ncs_high();

    // new frame_ready mid-transfer triggers a fresh header from address 0
    pulse_ready(1'b1);
    ncs_low();
    check("start_addr", 32'(rd_addr), 32'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back(i == 0 ? 16'hA5A1 : 16'(i - 1));
    spi_words(4);
    pulse_ready(1'b0);
    exp_q.push_back(16'h0003);
    spi_words(1);
    check("mid_busy", 32'(frame_busy), 32'd1);
    ncs_high();
    check("mid_abort_busy", 32'(frame_busy), 32'd0);
    ncs_low();
    check("restart_addr", 32'(rd_addr), 32'd0);
    exp_q.push_back(16'hA5A0);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    spi_words(3);
    ncs_high();

    // frame_ready in the same clock as the transfer start keeps the frame pending
    pulse_ready(1'b0);
    @(negedge clk);
    spi_ncs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(16'hA5A0);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    spi_words(3);
    ncs_high();
    buf_sel = 1'b1;
    ncs_low();
    exp_q.push_back(16'hA5A1);
    exp_q.push_back(16'h0000);
    spi_words(2);
    ncs_high();
    ncs_low();
    exp_q.push_back(16'h0000);
    spi_words(1);
    check("pending_cleared_busy", 32'(frame_busy), 32'd0);
    ncs_high();

    // reset asserted in the middle of a data word
    pulse_ready(1'b1);
    ncs_low();
    exp_q.push_back(16'hA5A1);
    spi_words(1);
    for (int b = 0; b < 5; b++) begin
      repeat (4) @(negedge clk);
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (2) @(negedge clk);
    spi_sck = 1'b1;
    check("pre_reset_busy", 32'(frame_busy), 32'd1);
    check("pre_reset_addr", 32'(rd_addr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(frame_busy), 32'd0);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_addr", 32'(rd_addr), 32'd0);
    spi_sck = 1'b0;
    spi_ncs = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
